// File: rtl/wb_port_arbiter.sv
// Two-source register-file write-back arbiter (ALU and load data), each source
// buffered by a 2-entry FIFO. Optional macro: WB_PORT_ARBITER_REG0_DISCARD_EN.
module wb_port_fifo #(
  parameter int W = 16,
  parameter int R = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [W-1:0]      res_i,
  input  logic [R-1:0]      idx_i,
  output logic              ready_o,
  output logic              nonempty_o,
  output logic [W-1:0]      head_res_o,
  output logic [R-1:0]      head_idx_o,
  output logic [(1<<R)-1:0] mask_o
);

  logic [1:0]   cnt_q,  cnt_d;
  logic [W-1:0] res0_q, res0_d, res1_q, res1_d;
  logic [R-1:0] idx0_q, idx0_d, idx1_q, idx1_d;
  logic [1:0]   base_cnt;

  assign ready_o    = (cnt_q != 2'd2);
  assign nonempty_o = (cnt_q != 2'd0);
  assign head_res_o = res0_q;
  assign head_idx_o = idx0_q;

  // Entry 0 is always the head; a pop shifts entry 1 down and a same-cycle
  // push lands in the slot freed by that shift, which keeps FIFO order.
  always_comb begin
    cnt_d    = cnt_q;
    res0_d   = res0_q;
    res1_d   = res1_q;
    idx0_d   = idx0_q;
    idx1_d   = idx1_q;
    base_cnt = cnt_q - {1'b0, pop_i};
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      if (pop_i) begin
        res0_d = res1_q;
        idx0_d = idx1_q;
      end
      if (push_i) begin
        if (base_cnt == 2'd0) begin
          res0_d = res_i;
          idx0_d = idx_i;
        end else begin
          res1_d = res_i;
          idx1_d = idx_i;
        end
      end
      cnt_d = base_cnt + {1'b0, push_i};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 2'd0;
      res0_q <= '0;
      res1_q <= '0;
      idx0_q <= '0;
      idx1_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      res0_q <= res0_d;
      res1_q <= res1_d;
      idx0_q <= idx0_d;
      idx1_q <= idx1_d;
    end
  end

  always_comb begin
    mask_o = '0;
    if (cnt_q != 2'd0) mask_o[idx0_q] = 1'b1;
    if (cnt_q == 2'd2) mask_o[idx1_q] = 1'b1;
  end

endmodule

// Handshake: a source transfers on a rising edge where x_valid && x_ready;
// x_ready depends only on registered occupancy, never on the same-cycle pop.
module wb_port_arbiter #(
  parameter int IALU_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH   = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_flush,
  input  logic                            alu_valid,
  output logic                            alu_ready,
  input  logic [IALU_WORD_WIDTH-1:0]      alu_res,
  input  logic [REG_IDX_WIDTH-1:0]        alu_reg_idx,
  input  logic                            mem_valid,
  output logic                            mem_ready,
  input  logic [IALU_WORD_WIDTH-1:0]      mem_res,
  input  logic [REG_IDX_WIDTH-1:0]        mem_reg_idx,
  output logic                            out_act_write_res_to_reg,
  output logic [IALU_WORD_WIDTH-1:0]      out_res,
  output logic [REG_IDX_WIDTH-1:0]        out_res_reg_idx,
  output logic [(1<<REG_IDX_WIDTH)-1:0]   pending_mask,
  output logic                            dbg_last_grant
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  localparam int NREG = 1 << REG_IDX_WIDTH;

  src_e                       last_grant_q;
  logic                       out_act_q;
  logic [IALU_WORD_WIDTH-1:0] out_res_q;
  logic [REG_IDX_WIDTH-1:0]   out_idx_q;

  logic                       alu_keep, mem_keep;
  logic                       alu_push, mem_push;
  logic                       alu_pop,  mem_pop;
  logic                       alu_ne,   mem_ne;
  logic                       grant_alu, grant_mem;
  logic [IALU_WORD_WIDTH-1:0] alu_head_res, mem_head_res;
  logic [REG_IDX_WIDTH-1:0]   alu_head_idx, mem_head_idx;
  logic [NREG-1:0]            alu_mask, mem_mask;

`ifdef WB_PORT_ARBITER_REG0_DISCARD_EN
  // Writes to register 0 still handshake but are dropped before queueing.
  assign alu_keep = (alu_reg_idx != '0);
  assign mem_keep = (mem_reg_idx != '0);
`else
  assign alu_keep = 1'b1;
  assign mem_keep = 1'b1;
`endif

  assign alu_push = alu_valid && alu_ready && !in_flush && alu_keep;
  assign mem_push = mem_valid && mem_ready && !in_flush && mem_keep;

  // Equal head indices mean a write-after-write hazard; the load is older.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (alu_ne && mem_ne) begin
      if (alu_head_idx == mem_head_idx) grant_mem = 1'b1;
      else if (last_grant_q == SRC_ALU) grant_mem = 1'b1;
      else                              grant_alu = 1'b1;
    end else if (mem_ne) begin
      grant_mem = 1'b1;
    end else if (alu_ne) begin
      grant_alu = 1'b1;
    end
  end

  assign alu_pop = grant_alu && !in_flush;
  assign mem_pop = grant_mem && !in_flush;

  wb_port_fifo #(.W(IALU_WORD_WIDTH), .R(REG_IDX_WIDTH)) u_alu_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush_i    (in_flush),
    .push_i     (alu_push),
    .pop_i      (alu_pop),
    .res_i      (alu_res),
    .idx_i      (alu_reg_idx),
    .ready_o    (alu_ready),
    .nonempty_o (alu_ne),
    .head_res_o (alu_head_res),
    .head_idx_o (alu_head_idx),
    .mask_o     (alu_mask)
  );

  wb_port_fifo #(.W(IALU_WORD_WIDTH), .R(REG_IDX_WIDTH)) u_mem_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush_i    (in_flush),
    .push_i     (mem_push),
    .pop_i      (mem_pop),
    .res_i      (mem_res),
    .idx_i      (mem_reg_idx),
    .ready_o    (mem_ready),
    .nonempty_o (mem_ne),
    .head_res_o (mem_head_res),
    .head_idx_o (mem_head_idx),
    .mask_o     (mem_mask)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_act_q    <= 1'b0;
      out_res_q    <= '0;
      out_idx_q    <= '0;
      last_grant_q <= SRC_ALU;
    end else if (in_flush) begin
      out_act_q <= 1'b0;
    end else if (grant_mem) begin
      out_act_q    <= 1'b1;
      out_res_q    <= mem_head_res;
      out_idx_q    <= mem_head_idx;
      last_grant_q <= SRC_MEM;
    end else if (grant_alu) begin
      out_act_q    <= 1'b1;
      out_res_q    <= alu_head_res;
      out_idx_q    <= alu_head_idx;
      last_grant_q <= SRC_ALU;
    end else begin
      out_act_q <= 1'b0;
    end
  end

  assign out_act_write_res_to_reg = out_act_q;
  assign out_res                  = out_res_q;
  assign out_res_reg_idx          = out_idx_q;
  assign pending_mask             = alu_mask | mem_mask;
  assign dbg_last_grant           = last_grant_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: queue-based reference model compared
// every cycle, plus hand-computed literal expectations for the directed scenarios.
module tb_wb_port_arbiter;

  localparam int W = 16;
  localparam int R = 4;
  localparam int N = 1 << R;

  typedef struct packed {
    logic [W-1:0] res;
    logic [R-1:0] idx;
  } ent_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_flush = 1'b0;
  logic          alu_valid = 1'b0;
  logic          alu_ready;
  logic [W-1:0]  alu_res = '0;
  logic [R-1:0]  alu_reg_idx = '0;
  logic          mem_valid = 1'b0;
  logic          mem_ready;
  logic [W-1:0]  mem_res = '0;
  logic [R-1:0]  mem_reg_idx = '0;
  logic          out_act;
  logic [W-1:0]  out_res;
  logic [R-1:0]  out_idx;
  logic [N-1:0]  pending_mask;
  logic          dbg_last_grant;

  int checks = 0;
  int failures = 0;

  wb_port_arbiter #(.IALU_WORD_WIDTH(W), .REG_IDX_WIDTH(R)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .in_flush                 (in_flush),
    .alu_valid                (alu_valid),
    .alu_ready                (alu_ready),
    .alu_res                  (alu_res),
    .alu_reg_idx              (alu_reg_idx),
    .mem_valid                (mem_valid),
    .mem_ready                (mem_ready),
    .mem_res                  (mem_res),
    .mem_reg_idx              (mem_reg_idx),
    .out_act_write_res_to_reg (out_act),
    .out_res                  (out_res),
    .out_res_reg_idx          (out_idx),
    .pending_mask             (pending_mask),
    .dbg_last_grant           (dbg_last_grant)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  ent_t         aq[$];
  ent_t         mq[$];
  logic         m_last_mem;
  logic         m_act;
  logic [W-1:0] m_res;
  logic [R-1:0] m_idx;

  function automatic logic keep_req(input logic [R-1:0] idx);
`ifdef WB_PORT_ARBITER_REG0_DISCARD_EN
    return idx != '0;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      aq.delete();
      mq.delete();
      m_last_mem = 1'b0;
      m_act = 1'b0;
      m_res = '0;
      m_idx = '0;
    end else begin
      automatic bit   a_rdy = aq.size() < 2;
      automatic bit   b_rdy = mq.size() < 2;
      automatic bit   take_mem = 1'b0;
      automatic bit   take_alu = 1'b0;
      automatic ent_t e;
      if (in_flush) begin
        aq.delete();
        mq.delete();
        m_act = 1'b0;
      end else begin
        if (aq.size() > 0 && mq.size() > 0)
          take_mem = (aq[0].idx == mq[0].idx) || !m_last_mem;
        else
          take_mem = mq.size() > 0;
        take_alu = (aq.size() > 0) && !take_mem;
        if (take_mem) begin
          e = mq.pop_front();
          m_act = 1'b1; m_res = e.res; m_idx = e.idx; m_last_mem = 1'b1;
        end else if (take_alu) begin
          e = aq.pop_front();
          m_act = 1'b1; m_res = e.res; m_idx = e.idx; m_last_mem = 1'b0;
        end else begin
          m_act = 1'b0;
        end
        if (alu_valid && a_rdy && keep_req(alu_reg_idx)) aq.push_back('{alu_res, alu_reg_idx});
        if (mem_valid && b_rdy && keep_req(mem_reg_idx)) mq.push_back('{mem_res, mem_reg_idx});
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] exp_mask;
    exp_mask = '0;
    foreach (aq[i]) exp_mask[aq[i].idx] = 1'b1;
    foreach (mq[i]) exp_mask[mq[i].idx] = 1'b1;
    check("model_out_act", {31'd0, out_act}, {31'd0, m_act});
    check("model_out_res", {16'd0, out_res}, {16'd0, m_res});
    check("model_out_idx", {28'd0, out_idx}, {28'd0, m_idx});
    check("model_alu_ready", {31'd0, alu_ready}, {31'd0, aq.size() < 2});
    check("model_mem_ready", {31'd0, mem_ready}, {31'd0, mq.size() < 2});
    check("model_pending", {16'd0, pending_mask}, {16'd0, exp_mask});
    check("model_last_grant", {31'd0, dbg_last_grant}, {31'd0, m_last_mem});
  endtask

  // One clock edge, then compare at the following falling edge; inputs are
  // driven by the caller right after return, well away from the rising edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    in_flush  = 1'b0;
  endtask

  task automatic drive_alu(input logic [W-1:0] r, input logic [R-1:0] i);
    alu_valid = 1'b1; alu_res = r; alu_reg_idx = i;
  endtask

  task automatic drive_mem(input logic [W-1:0] r, input logic [R-1:0] i);
    mem_valid = 1'b1; mem_res = r; mem_reg_idx = i;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    do_reset();
    check("reset_out_act", {31'd0, out_act}, 32'd0);
    check("reset_out_res", {16'd0, out_res}, 32'd0);
    check("reset_out_idx", {28'd0, out_idx}, 32'd0);
    check("reset_readies", {30'd0, alu_ready, mem_ready}, 32'd3);
    check("reset_pending", {16'd0, pending_mask}, 32'd0);

    // Single ALU write, 1-cycle latency.
    drive_alu(16'h1234, 4'd3);
    tick();
    idle();
    check("alu_only_pending", {16'd0, pending_mask}, 32'h0008);
    check("alu_only_act_e1", {31'd0, out_act}, 32'd0);
    tick();
    check("alu_only_act", {31'd0, out_act}, 32'd1);
    check("alu_only_res", {16'd0, out_res}, 32'h1234);
    check("alu_only_idx", {28'd0, out_idx}, 32'd3);
    check("alu_only_pending_e2", {16'd0, pending_mask}, 32'd0);
    tick();
    check("alu_only_idle", {31'd0, out_act}, 32'd0);

    // Contention after reset: MEM, ALU, MEM, ALU.
    do_reset();
    drive_alu(16'hA001, 4'd1);
    drive_mem(16'hB002, 4'd2);
    tick();
    tick();
    check("contend_g1", {27'd0, out_act, out_idx}, 32'h12);
    tick();
    check("contend_g2", {27'd0, out_act, out_idx}, 32'h11);
    tick();
    check("contend_g3", {27'd0, out_act, out_idx}, 32'h12);
    idle();
    tick();
    check("contend_g4", {27'd0, out_act, out_idx}, 32'h11);
    for (int k = 0; k < 6; k++) tick();

    // Same-index hazard: the load writes first.
    drive_alu(16'hAAAA, 4'd5);
    drive_mem(16'hBBBB, 4'd5);
    tick();
    idle();
    check("hazard_pending", {16'd0, pending_mask}, 32'h0020);
    tick();
    check("hazard_first_res", {16'd0, out_res}, 32'hBBBB);
    check("hazard_first_idx", {28'd0, out_idx}, 32'd5);
    tick();
    check("hazard_second_res", {16'd0, out_res}, 32'hAAAA);
    check("hazard_second_act", {31'd0, out_act}, 32'd1);
    tick();

    // MEM FIFO fills while ALU holds the grant for one cycle.
    drive_alu(16'h0808, 4'd8);
    drive_mem(16'h0909, 4'd9);
    tick();
    alu_valid = 1'b0;
    drive_mem(16'hC001, 4'd10);
    tick();
    check("full_g_mem", {28'd0, out_idx}, 32'd9);
    drive_mem(16'hC002, 4'd11);
    tick();
    check("full_g_alu", {28'd0, out_idx}, 32'd8);
    check("full_mem_ready0", {31'd0, mem_ready}, 32'd0);
    drive_mem(16'hC003, 4'd12);
    tick();
    check("full_pop_c001", {16'd0, out_res}, 32'hC001);
    check("full_mem_ready1", {31'd0, mem_ready}, 32'd1);
    tick();
    idle();
    check("full_pop_c002", {16'd0, out_res}, 32'hC002);
    tick();
    check("full_pop_c003", {16'd0, out_res}, 32'hC003);
    tick();
    tick();

    // Flush with traffic queued and requests still asserted.
    drive_alu(16'hD001, 4'd6);
    drive_mem(16'hE001, 4'd7);
    tick();
    tick();
    tick();
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    idle();
    check("flush_act", {31'd0, out_act}, 32'd0);
    check("flush_pending", {16'd0, pending_mask}, 32'd0);
    check("flush_readies", {30'd0, alu_ready, mem_ready}, 32'd3);
    tick();
    check("flush_no_write", {31'd0, out_act}, 32'd0);

    // Asynchronous reset mid-operation discards queued entries.
    drive_alu(16'hF001, 4'd12);
    drive_mem(16'hF002, 4'd13);
    tick();
    idle();
    #2 reset = 1'b0;
    #1;
    check("arst_pending", {16'd0, pending_mask}, 32'd0);
    check("arst_out_act", {31'd0, out_act}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("arst_no_write", {31'd0, out_act}, 32'd0);
    check("arst_out_res", {16'd0, out_res}, 32'd0);

    // Register-0 handling.
    drive_alu(16'h5A5A, 4'd0);
    tick();
    idle();
`ifdef WB_PORT_ARBITER_REG0_DISCARD_EN
    check("reg0_pending", {16'd0, pending_mask}, 32'd0);
    tick();
    check("reg0_no_write", {31'd0, out_act}, 32'd0);
`else
    check("reg0_pending", {16'd0, pending_mask}, 32'd1);
    tick();
    check("reg0_write_act", {31'd0, out_act}, 32'd1);
    check("reg0_write_res", {16'd0, out_res}, 32'h5A5A);
    check("reg0_write_idx", {28'd0, out_idx}, 32'd0);
`endif
    tick();

    // Mixed directed table: back-to-back traffic from both sources.
    for (int k = 0; k < 8; k++) begin
      if (k % 3 != 2) drive_alu(16'h7000 + 16'(k), 4'(k + 1)); else alu_valid = 1'b0;
      if (k % 2 == 0) drive_mem(16'h8000 + 16'(k), 4'(k % 4 + 1)); else mem_valid = 1'b0;
      tick();
    end
    idle();
    for (int k = 0; k < 6; k++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have parameter IALU_WORD_WIDTH, default 16, giving the result data width.
REQ-002 The block SHALL have parameter REG_IDX_WIDTH, default 4, giving the register index width; there are NREG = 2^REG_IDX_WIDTH registers.
REQ-003 Port clock  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-005 Port in_flush  input  1  is a synchronous request to discard all queued writes.
REQ-006 Port alu_valid  input  1  marks an ALU write request.
REQ-007 Port alu_ready  output  1  marks free space in the ALU queue.
REQ-008 Port alu_res  input  IALU_WORD_WIDTH  is the ALU write data.
REQ-009 Port alu_reg_idx  input  REG_IDX_WIDTH  is the ALU destination register.
REQ-010 Ports mem_valid, mem_ready, mem_res and mem_reg_idx SHALL match the alu_* ports for the load-data source.
REQ-011 Port out_act_write_res_to_reg  output  1  is the register-file write enable.
REQ-012 Port out_res  output  IALU_WORD_WIDTH  is the register-file write data.
REQ-013 Port out_res_reg_idx  output  REG_IDX_WIDTH  is the register-file write index.
REQ-014 Port pending_mask  output  NREG  sets bit i while any queued entry targets register i.

Function
REQ-015 Each source SHALL own a 2-entry FIFO holding {res, reg_idx} plus a registered occupancy count (0..2).
REQ-016 x_ready SHALL be 1 iff the x occupancy count < 2, from registered state only; a dequeue in the same cycle does not raise ready.
REQ-017 An entry SHALL be enqueued on a rising edge where x_valid && x_ready && !in_flush.
REQ-018 Each cycle the arbiter SHALL select at most one non-empty FIFO head, pop it, and register it onto out_* with out_act_write_res_to_reg=1 on the next edge.
REQ-019 If no head is selected, out_act_write_res_to_reg SHALL be 0 next cycle; out_res and out_res_reg_idx hold their values.
REQ-020 Latency SHALL be 1 cycle: an entry accepted into an empty, granted FIFO at edge N is written at edge N+1.
REQ-021 The arbiter SHALL keep a 1-bit last_grant state, either ALU or MEM.
REQ-022 With exactly one FIFO non-empty, that FIFO SHALL be granted.
REQ-023 With both FIFOs non-empty and different head reg_idx values, the source opposite last_grant SHALL be granted.
REQ-024 With both FIFOs non-empty and equal head reg_idx values, MEM SHALL be granted because the load is the older instruction.
REQ-025 last_grant SHALL update to the granted source on every grant.
REQ-026 No source SHALL wait more than 2 grant cycles while its FIFO is non-empty.
REQ-027 pending_mask SHALL be combinational: the OR of one-hot decodes of all valid FIFO entries.
REQ-028 When in_flush=1, both counts SHALL clear and out_act_write_res_to_reg SHALL be 0 on the next edge; same-cycle enqueues and grants are dropped.
REQ-029 Simultaneous enqueue and dequeue on one FIFO SHALL leave the count unchanged and preserve FIFO order.

Reset
REQ-030 While reset=0, the block SHALL clear both FIFO counts and drive out_act_write_res_to_reg=0, out_res=0 and out_res_reg_idx=0.
REQ-031 While reset=0, last_grant SHALL be ALU, so MEM wins the first contended cycle.
REQ-032 While reset=0, alu_ready=1, mem_ready=1 and pending_mask=0 SHALL follow from the cleared counts.
REQ-033 Reset asserted mid-operation SHALL discard all queued entries without issuing their writes.

Configuration
REQ-034 The macro WB_PORT_ARBITER_REG0_DISCARD_EN SHALL select the register-0 behaviour.
REQ-035 With the macro defined, a request with reg_idx=0 SHALL complete its handshake and not be enqueued, so it never writes and pending_mask[0] stays 0.
REQ-036 With the macro undefined, register 0 SHALL be treated like any other register.

Verification
REQ-037 ALU-only test: alu req {res=0x1234, idx=3} at edge 1 SHALL give out_act=1, out_res=0x1234, out_idx=3 at edge 2, with pending_mask=0x0008 between the edges.
REQ-038 Contention test: both sources valid every cycle with distinct indices after reset SHALL give grants in the order MEM, ALU, MEM, ALU.
REQ-039 Hazard test: ALU {0xAAAA, idx 5} and MEM {0xBBBB, idx 5} enqueued in the same cycle SHALL write MEM 0xBBBB first, then ALU 0xAAAA.
REQ-040 Full test: three back-to-back mem_valid with no grant possible SHALL show mem_ready=0 after 2 accepts, with the 3rd held until a pop.
REQ-041 Flush test: both FIFOs full plus in_flush=1 SHALL give out_act=0 next cycle, pending_mask=0, and both readies=1.
REQ-042 Macro test: alu req idx=0 SHALL give no write with the macro defined and a write to idx 0 with it undefined.
